// File: rtl/vx_sau_unit.sv
// vx_sau_unit: SAU execution unit.
// It accepts one warp-wide request, processes LANES threads per EXEC beat and
// holds a single commit response until the commit stage takes it. Only one
// request is in flight at a time.
module vx_sau_unit #(
  parameter int CORE_ID     = 0,
  parameter int LANES       = 1,   // must divide NUM_THREADS
  parameter int NUM_THREADS = 4,
  parameter int UUID_BITS   = 44,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5,
  parameter int OP_BITS     = 4,   // must be > 2
  parameter int MOD_BITS    = 3
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  // request channel (slave)
  input  logic                        sau_req_valid_i,
  input  logic [UUID_BITS-1:0]        sau_req_uuid_i,
  input  logic [NW_BITS-1:0]          sau_req_wid_i,
  input  logic [NUM_THREADS-1:0]      sau_req_tmask_i,
  input  logic [31:0]                 sau_req_pc_i,
  input  logic [OP_BITS-1:0]          sau_req_op_type_i,
  input  logic [MOD_BITS-1:0]         sau_req_op_mod_i,
  input  logic [NUM_THREADS*32-1:0]   sau_req_rs1_data_i,
  input  logic [NUM_THREADS*32-1:0]   sau_req_rs2_data_i,
  input  logic [NR_BITS-1:0]          sau_req_rd_i,
  input  logic                        sau_req_wb_i,
  output logic                        sau_req_ready_o,
  // commit response
  output logic                        rsp_valid_o,
  output logic [UUID_BITS-1:0]        rsp_uuid_o,
  output logic [NW_BITS-1:0]          rsp_wid_o,
  output logic [NUM_THREADS-1:0]      rsp_tmask_o,
  output logic [31:0]                 rsp_pc_o,
  output logic [NR_BITS-1:0]          rsp_rd_o,
  output logic                        rsp_wb_o,
  output logic [NUM_THREADS*32-1:0]   rsp_data_o,
  output logic                        rsp_eop_o,
  input  logic                        rsp_ready_i
);

  localparam int BEATS     = NUM_THREADS / LANES;
  localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TID_BITS  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  // Internal operation code; anything with non-zero upper op_type bits
  // collapses to OP_INV so the datapath never sees it.
  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_MULH = 3'd1;
  localparam logic [2:0] OP_DOT  = 3'd2;
  localparam logic [2:0] OP_ABSD = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic                        accept;
  logic                        last_beat;

  logic [UUID_BITS-1:0]        uuid_q;
  logic [NW_BITS-1:0]          wid_q;
  logic [NUM_THREADS-1:0]      tmask_q;
  logic [31:0]                 pc_q;
  logic [NR_BITS-1:0]          rd_q;
  logic                        wb_q;
  logic [2:0]                  op_q;
  logic                        mulh_signed_q;
  logic [NUM_THREADS*32-1:0]   rs1_q;
  logic [NUM_THREADS*32-1:0]   rs2_q;
  logic [BEAT_BITS-1:0]        beat_q;
  logic [31:0]                 acc_q, acc_d;
  logic [2:0]                  op_dec;

  logic [31:0]                 lane_res [LANES];
  logic [31:0]                 lane_dot [LANES];

  assign accept    = sau_req_valid_i && (state_q == S_IDLE);
  assign last_beat = (beat_q == BEAT_BITS'(BEATS - 1));
  assign op_dec    = ((sau_req_op_type_i >> 2) != '0) ? OP_INV
                                                      : {1'b0, sau_req_op_type_i[1:0]};

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one pass of BEATS cycles, then hold the response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (sau_req_valid_i) state_d = S_EXEC;
      S_EXEC: if (last_beat)       state_d = S_RSP;
      S_RSP:  if (rsp_ready_i)     state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; ready never rises in the same
  // cycle as the response handshake, so at most one request is outstanding.
  always_comb begin
    sau_req_ready_o = 1'b0;
    rsp_valid_o     = 1'b0;
    case (state_q)
      S_IDLE:  sau_req_ready_o = 1'b1;
      S_RSP:   rsp_valid_o     = 1'b1;
      default: ;
    endcase
  end

  // Request capture, beat counter and DOT accumulator.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      uuid_q        <= '0;
      wid_q         <= '0;
      tmask_q       <= '0;
      pc_q          <= '0;
      rd_q          <= '0;
      wb_q          <= 1'b0;
      op_q          <= OP_MUL;
      mulh_signed_q <= 1'b0;
      beat_q        <= '0;
      acc_q         <= '0;
    end else if (accept) begin
      uuid_q        <= sau_req_uuid_i;
      wid_q         <= sau_req_wid_i;
      tmask_q       <= sau_req_tmask_i;
      pc_q          <= sau_req_pc_i;
      rd_q          <= sau_req_rd_i;
      wb_q          <= sau_req_wb_i;
      op_q          <= op_dec;
      mulh_signed_q <= sau_req_op_mod_i[0];
      beat_q        <= '0;
      acc_q         <= '0;
    end else if (state_q == S_EXEC) begin
      beat_q        <= last_beat ? '0 : beat_q + BEAT_BITS'(1);
      acc_q         <= acc_d;
    end
  end

  // Operand capture; operands are only consumed after an accept, so they
  // need no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      rs1_q <= sau_req_rs1_data_i;
      rs2_q <= sau_req_rs2_data_i;
    end
  end

  // Per-lane arithmetic on the thread selected by the current beat.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [TID_BITS-1:0]  tid;
      logic [31:0]          op_a, op_b;
      logic                 active;
      logic [63:0]          prod_u;
      logic signed [63:0]   prod_s;
      logic [31:0]          diff;
      logic [31:0]          absd;
      logic [31:0]          res;

      assign tid    = TID_BITS'(int'(beat_q) * LANES + gi);
      assign op_a   = rs1_q[{tid, 5'd0} +: 32];
      assign op_b   = rs2_q[{tid, 5'd0} +: 32];
      assign active = tmask_q[tid];
      assign prod_u = {32'd0, op_a} * {32'd0, op_b};
      assign prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
      // Wrapped 32-bit difference; negating 0x80000000 leaves it unchanged.
      assign diff   = op_a - op_b;
      assign absd   = diff[31] ? (32'd0 - diff) : diff;

      // Result written back for this lane's thread; DOT lanes only feed acc.
      always_comb begin
        res = '0;
        if (active) begin
          case (op_q)
            OP_MUL:  res = prod_u[31:0];
            OP_MULH: res = mulh_signed_q ? prod_s[63:32] : prod_u[63:32];
            OP_ABSD: res = absd;
            default: res = '0;
          endcase
        end
      end

      assign lane_res[gi] = res;
      assign lane_dot[gi] = (active && (op_q == OP_DOT)) ? prod_u[31:0] : 32'd0;
    end
  endgenerate

  // Accumulator update for the current beat, wrapping mod 2^32.
  always_comb begin
    acc_d = acc_q;
    for (int l = 0; l < LANES; l++) begin
      acc_d = acc_d + lane_dot[l];
    end
  end

  // Per-thread result registers, written on the beat that owns the thread.
  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
      localparam int BEAT_IDX = gi / LANES;
      localparam int LANE_IDX = gi % LANES;
      logic [31:0] data_q;

      // Capture this thread's lane result during its beat.
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          data_q <= '0;
        end else if ((state_q == S_EXEC) && (beat_q == BEAT_BITS'(BEAT_IDX))) begin
          data_q <= lane_res[LANE_IDX];
        end
      end

      // DOT broadcasts the final sum to every active thread.
      assign rsp_data_o[gi*32 +: 32] = (op_q == OP_DOT) ? (tmask_q[gi] ? acc_q : 32'd0)
                                                        : data_q;
    end
  endgenerate

  assign rsp_uuid_o  = uuid_q;
  assign rsp_wid_o   = wid_q;
  assign rsp_tmask_o = tmask_q;
  assign rsp_pc_o    = pc_q;
  assign rsp_rd_o    = rd_q;
  assign rsp_wb_o    = wb_q;
  assign rsp_eop_o   = 1'b1;

  // CORE_ID only identifies the core in debug traces; upper op_mod bits are
  // reserved for other units.
  logic unused_sig;
  assign unused_sig = ^{32'(CORE_ID), sau_req_op_mod_i};

endmodule

// File: tb/tb_vx_sau_unit.sv
// tb_vx_sau_unit: self-checking bench for vx_sau_unit.
// Instance A uses LANES=1, instance B uses LANES=2; both see 4 threads.
// Expected data comes from a plain-arithmetic model of the SAU operations.
module tb_vx_sau_unit;
  localparam int NT  = 4;
  localparam int UB  = 44;
  localparam int NWB = 2;
  localparam int NRB = 5;
  localparam int OPB = 4;
  localparam int MB  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic va, vb, rra, rrb;
  logic [UB-1:0]    uuid;
  logic [NWB-1:0]   wid;
  logic [NT-1:0]    tmask;
  logic [31:0]      pc;
  logic [OPB-1:0]   op;
  logic [MB-1:0]    mod;
  logic [NT*32-1:0] rs1, rs2;
  logic [NRB-1:0]   rd;
  logic             wb;

  logic a_ready, a_valid, a_wb, a_eop, b_ready, b_valid, b_wb, b_eop;
  logic [UB-1:0]    a_uuid, b_uuid;
  logic [NWB-1:0]   a_wid, b_wid;
  logic [NT-1:0]    a_tmask, b_tmask;
  logic [31:0]      a_pc, b_pc;
  logic [NRB-1:0]   a_rd, b_rd;
  logic [NT*32-1:0] a_data, b_data;

  vx_sau_unit #(.CORE_ID(0), .LANES(1), .NUM_THREADS(NT), .UUID_BITS(UB), .NW_BITS(NWB),
                .NR_BITS(NRB), .OP_BITS(OPB), .MOD_BITS(MB)) dut_a (
    .clk_i(clk), .reset_i(reset),
    .sau_req_valid_i(va), .sau_req_uuid_i(uuid), .sau_req_wid_i(wid), .sau_req_tmask_i(tmask),
    .sau_req_pc_i(pc), .sau_req_op_type_i(op), .sau_req_op_mod_i(mod),
    .sau_req_rs1_data_i(rs1), .sau_req_rs2_data_i(rs2), .sau_req_rd_i(rd), .sau_req_wb_i(wb),
    .sau_req_ready_o(a_ready),
    .rsp_valid_o(a_valid), .rsp_uuid_o(a_uuid), .rsp_wid_o(a_wid), .rsp_tmask_o(a_tmask),
    .rsp_pc_o(a_pc), .rsp_rd_o(a_rd), .rsp_wb_o(a_wb), .rsp_data_o(a_data), .rsp_eop_o(a_eop),
    .rsp_ready_i(rra)
  );

  vx_sau_unit #(.CORE_ID(1), .LANES(2), .NUM_THREADS(NT), .UUID_BITS(UB), .NW_BITS(NWB),
                .NR_BITS(NRB), .OP_BITS(OPB), .MOD_BITS(MB)) dut_b (
    .clk_i(clk), .reset_i(reset),
    .sau_req_valid_i(vb), .sau_req_uuid_i(uuid), .sau_req_wid_i(wid), .sau_req_tmask_i(tmask),
    .sau_req_pc_i(pc), .sau_req_op_type_i(op), .sau_req_op_mod_i(mod),
    .sau_req_rs1_data_i(rs1), .sau_req_rs2_data_i(rs2), .sau_req_rd_i(rd), .sau_req_wb_i(wb),
    .sau_req_ready_o(b_ready),
    .rsp_valid_o(b_valid), .rsp_uuid_o(b_uuid), .rsp_wid_o(b_wid), .rsp_tmask_o(b_tmask),
    .rsp_pc_o(b_pc), .rsp_rd_o(b_rd), .rsp_wb_o(b_wb), .rsp_data_o(b_data), .rsp_eop_o(b_eop),
    .rsp_ready_i(rrb)
  );

  // Selected-DUT view used by the transaction driver.
  logic cur_b;
  logic m_ready, m_valid;
  logic [NT*32-1:0] m_data;
  logic [UB-1:0] m_uuid;
  assign m_ready = cur_b ? b_ready : a_ready;
  assign m_valid = cur_b ? b_valid : a_valid;
  assign m_data  = cur_b ? b_data  : a_data;
  assign m_uuid  = cur_b ? b_uuid  : a_uuid;

  int checks = 0;
  int errors = 0;

  // Snapshot of the last transaction run through run_req.
  int               s_lat;
  bit               s_timeout, s_ready_low, s_ready_after, s_valid_after;
  logic [NT*32-1:0] s_data;
  logic [UB-1:0]    s_uuid;
  logic [NWB-1:0]   s_wid;
  logic [NT-1:0]    s_tmask;
  logic [31:0]      s_pc;
  logic [NRB-1:0]   s_rd;
  logic             s_wb, s_eop;

  // Reference: per-thread SAU result from the operation definitions.
  function automatic logic [NT*32-1:0] model(input logic [OPB-1:0] o, input logic [MB-1:0] m,
                                             input logic [NT-1:0] tm,
                                             input logic [NT*32-1:0] x, input logic [NT*32-1:0] y);
    logic [NT*32-1:0] r;
    logic [31:0] a, b;
    logic [63:0] pu;
    longint ps;
    int da;
    longint unsigned sum;
    r = '0;
    sum = 0;
    for (int t = 0; t < NT; t++) begin
      a  = x[t*32 +: 32];
      b  = y[t*32 +: 32];
      pu = 64'(a) * 64'(b);
      ps = longint'($signed(a)) * longint'($signed(b));
      da = $signed(a) - $signed(b);
      if (tm[t]) begin
        case (o)
          4'd0: r[t*32 +: 32] = pu[31:0];
          4'd1: r[t*32 +: 32] = m[0] ? ps[63:32] : pu[63:32];
          4'd2: sum = sum + 64'(pu[31:0]);
          4'd3: r[t*32 +: 32] = (da < 0) ? -da : da;
          default: r[t*32 +: 32] = 32'd0;
        endcase
      end
    end
    if (o == 4'd2)
      for (int t = 0; t < NT; t++)
        if (tm[t]) r[t*32 +: 32] = sum[31:0];
    return r;
  endfunction

  // Drive the current request fields into the selected DUT, wait for the
  // response (bounded), record it and complete the handshake.
  task automatic run_req();
    int k;
    s_timeout   = 1'b0;
    s_ready_low = 1'b1;
    @(negedge clk);
    if (cur_b) begin vb = 1'b1; rrb = 1'b1; end else begin va = 1'b1; rra = 1'b1; end
    k = 0;
    while (!m_ready && k < 50) begin @(negedge clk); k++; end
    if (!m_ready) begin
      s_timeout = 1'b1; va = 1'b0; vb = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    va = 1'b0; vb = 1'b0;
    k = 1;
    while (!m_valid && k < 50) begin
      if (m_ready) s_ready_low = 1'b0;
      @(negedge clk);
      k++;
    end
    if (m_ready) s_ready_low = 1'b0;
    if (!m_valid) begin s_timeout = 1'b1; return; end
    s_lat  = k;
    s_data = m_data;
    s_uuid = m_uuid;
    s_wid   = cur_b ? b_wid : a_wid;
    s_tmask = cur_b ? b_tmask : a_tmask;
    s_pc    = cur_b ? b_pc : a_pc;
    s_rd    = cur_b ? b_rd : a_rd;
    s_wb    = cur_b ? b_wb : a_wb;
    s_eop   = cur_b ? b_eop : a_eop;
    @(posedge clk);
    @(negedge clk);
    s_ready_after = m_ready;
    s_valid_after = m_valid;
    $display("txn dut=%s op=%0d mod=%0d tmask=%b lat=%0d data=%h", cur_b ? "B" : "A",
             op, mod, tmask, s_lat, s_data);
  endtask

  task automatic rand_fields();
    uuid  = UB'({$urandom, $urandom});
    wid   = NWB'($urandom);
    pc    = $urandom;
    rd    = NRB'($urandom);
    wb    = 1'($urandom);
    tmask = NT'($urandom);
    mod   = MB'($urandom);
    rs1   = {$urandom, $urandom, $urandom, $urandom};
    rs2   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic test_reset();
    reset = 1'b1; va = 1'b1; vb = 1'b1; rra = 1'b0; rrb = 1'b0; cur_b = 1'b0;
    rand_fields(); op = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0; va = 1'b0; vb = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got a=%b b=%b expected 1", a_ready, b_ready);
    end
    checks++;
    if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got a=%b b=%b expected 0", a_valid, b_valid);
    end
    checks++;
    if (a_data !== '0 || a_uuid !== '0 || a_tmask !== '0 || a_pc !== '0 || a_rd !== '0 ||
        a_wb !== 1'b0 || a_wid !== '0 || b_data !== '0) begin
      errors++; $display("FAIL reset_fields: got data=%h uuid=%h pc=%h expected zeros", a_data, a_uuid, a_pc);
    end
    checks++;
    if (a_eop !== 1'b1) begin errors++; $display("FAIL reset_eop: got %b expected 1", a_eop); end
  endtask

  task automatic test_mul();
    cur_b = 1'b0; rand_fields();
    op = 4'd0; tmask = 4'hF; wb = 1'b1;
    rs1 = {32'd7, 32'hFFFFFFFF, 32'd3, 32'd2};
    rs2 = {32'd0, 32'd2, 32'd4, 32'd5};
    run_req();
    checks++;
    if (s_timeout) begin errors++; $display("FAIL mul_timeout: no response within bound"); end
    checks++;
    if (s_data !== {32'd0, 32'hFFFFFFFE, 32'd12, 32'd10}) begin
      errors++; $display("FAIL mul_data: got %h expected 00000000fffffffe0000000c0000000a", s_data);
    end
    checks++;
    if (s_lat != 5) begin errors++; $display("FAIL mul_latency: got %0d expected 5", s_lat); end
    checks++;
    if (!s_ready_low) begin errors++; $display("FAIL mul_ready_low: ready seen high while busy"); end
    checks++;
    if (s_uuid !== uuid || s_wid !== wid || s_tmask !== tmask || s_pc !== pc ||
        s_rd !== rd || s_wb !== wb || s_eop !== 1'b1) begin
      errors++; $display("FAIL mul_fields: got uuid=%h pc=%h rd=%0d expected uuid=%h pc=%h rd=%0d",
                         s_uuid, s_pc, s_rd, uuid, pc, rd);
    end
    checks++;
    if (s_ready_after !== 1'b1 || s_valid_after !== 1'b0) begin
      errors++; $display("FAIL mul_after_hs: got ready=%b valid=%b expected 1/0", s_ready_after, s_valid_after);
    end
  endtask

  task automatic test_dot();
    cur_b = 1'b0; rand_fields();
    op = 4'd2; tmask = 4'b1011;
    rs1 = {32'd4, 32'd3, 32'd2, 32'd1};
    rs2 = {32'd1, 32'd1, 32'd1, 32'd1};
    run_req();
    checks++;
    if (s_timeout || s_data !== {32'd7, 32'd0, 32'd7, 32'd7}) begin
      errors++; $display("FAIL dot_data: got %h expected 00000007000000000000000700000007 (timeout=%b)", s_data, s_timeout);
    end
  endtask

  task automatic test_mulh();
    cur_b = 1'b0; rand_fields();
    op = 4'd1; mod = 3'd1; tmask = 4'hF;
    rs1[31:0] = 32'hFFFFFFFF; rs2[31:0] = 32'd2;
    run_req();
    checks++;
    if (s_timeout || s_data[31:0] !== 32'hFFFFFFFF || s_data !== model(op, mod, tmask, rs1, rs2)) begin
      errors++; $display("FAIL mulh_signed: got %h expected %h", s_data, model(op, mod, tmask, rs1, rs2));
    end
    mod = 3'd0;
    run_req();
    checks++;
    if (s_timeout || s_data[31:0] !== 32'h00000001 || s_data !== model(op, mod, tmask, rs1, rs2)) begin
      errors++; $display("FAIL mulh_unsigned: got %h expected %h", s_data, model(op, mod, tmask, rs1, rs2));
    end
  endtask

  task automatic test_absdiff();
    cur_b = 1'b0; rand_fields();
    op = 4'd3; tmask = 4'hF;
    rs1 = {32'h7FFFFFFF, 32'hFFFFFFFB, 32'd3, 32'h80000000};
    rs2 = {32'h80000000, 32'd5, 32'd10, 32'd0};
    run_req();
    checks++;
    if (s_timeout || s_data !== {32'd1, 32'd10, 32'd7, 32'h80000000}) begin
      errors++; $display("FAIL absdiff_data: got %h expected 000000010000000a0000000780000000", s_data);
    end
  endtask

  task automatic test_backpressure();
    logic [NT*32-1:0] exp1, exp2, snap_data;
    logic [UB-1:0] snap_uuid, uuid2;
    bit stable;
    int k;
    cur_b = 1'b0; rand_fields(); op = 4'd0;
    exp1 = model(op, mod, tmask, rs1, rs2);
    @(negedge clk);
    va = 1'b1; rra = 1'b0;
    k = 0;
    while (!a_ready && k < 50) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    rand_fields(); op = 4'd3;   // held valid while busy: must not be taken
    k = 0;
    while (!a_valid && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (!a_valid || a_data !== exp1) begin
      errors++; $display("FAIL bp_first_data: got valid=%b data=%h expected 1/%h", a_valid, a_data, exp1);
    end
    snap_data = a_data; snap_uuid = a_uuid; stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (a_data !== snap_data || a_uuid !== snap_uuid || !a_valid || a_ready) stable = 1'b0;
      rand_fields(); op = 4'($urandom_range(0, 3));
      @(negedge clk);
    end
    checks++;
    if (!stable || a_data !== snap_data || !a_valid) begin
      errors++; $display("FAIL bp_stable: rsp changed or ready rose during stall (data=%h expected %h)", a_data, snap_data);
    end
    exp2 = model(op, mod, tmask, rs1, rs2); uuid2 = uuid;
    rra = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || a_valid !== 1'b0) begin
      errors++; $display("FAIL bp_after_hs: got ready=%b valid=%b expected 1/0", a_ready, a_valid);
    end
    @(posedge clk);
    @(negedge clk);
    va = 1'b0;
    checks++;
    if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_accept_next: got ready=%b expected 0", a_ready); end
    k = 0;
    while (!a_valid && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (!a_valid || a_data !== exp2 || a_uuid !== uuid2) begin
      errors++; $display("FAIL bp_second_data: got %h uuid=%h expected %h uuid=%h", a_data, a_uuid, exp2, uuid2);
    end
    $display("txn dut=A op=%0d backpressure second response data=%h", op, a_data);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_exec();
    bit seen;
    logic [NT*32-1:0] exp;
    cur_b = 1'b0; rand_fields(); op = 4'd0; tmask = 4'hF;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_exec_pre_ready: got %b expected 1", a_ready); end
    va = 1'b1; rra = 1'b1;
    @(posedge clk);
    @(negedge clk);
    va = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (a_ready !== 1'b1 || a_valid !== 1'b0 || a_data !== '0 || a_uuid !== '0) begin
      errors++; $display("FAIL rst_exec_state: got ready=%b valid=%b data=%h expected 1/0/0", a_ready, a_valid, a_data);
    end
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (a_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_exec_no_rsp: got response after reset expected none"); end
    rand_fields(); op = 4'd1;
    exp = model(op, mod, tmask, rs1, rs2);
    run_req();
    checks++;
    if (s_timeout || s_data !== exp || s_lat != 5) begin
      errors++; $display("FAIL rst_exec_next: got %h lat=%0d expected %h lat=5", s_data, s_lat, exp);
    end
  endtask

  task automatic test_random();
    logic [NT*32-1:0] exp;
    for (int n = 0; n < 30; n++) begin
      cur_b = (n % 3 == 2);
      rand_fields();
      op = ($urandom_range(0, 9) > 7) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      if (n % 7 == 0) tmask = '0;
      exp = model(op, mod, tmask, rs1, rs2);
      run_req();
      checks++;
      if (s_timeout || s_data !== exp) begin
        errors++; $display("FAIL rand_data[%0d]: got %h expected %h op=%0d tmask=%b", n, s_data, exp, op, tmask);
      end
      checks++;
      if (s_lat != (cur_b ? 3 : 5) || s_uuid !== uuid || s_wb !== wb) begin
        errors++; $display("FAIL rand_meta[%0d]: got lat=%0d uuid=%h wb=%b expected lat=%0d uuid=%h wb=%b",
                           n, s_lat, s_uuid, s_wb, cur_b ? 3 : 5, uuid, wb);
      end
    end
    cur_b = 1'b0;
  endtask

  task automatic test_lanes2();
    logic [NT*32-1:0] exp;
    cur_b = 1'b1; rand_fields();
    op = 4'd4; tmask = 4'hF;
    run_req();
    checks++;
    if (s_timeout || s_data !== '0) begin errors++; $display("FAIL l2_invalid: got %h expected 0", s_data); end
    checks++;
    if (s_lat != 3) begin errors++; $display("FAIL l2_latency: got %0d expected 3", s_lat); end
    rand_fields(); op = 4'd2;
    exp = model(op, mod, tmask, rs1, rs2);
    run_req();
    checks++;
    if (s_timeout || s_data !== exp) begin errors++; $display("FAIL l2_dot: got %h expected %h", s_data, exp); end
    rand_fields(); op = 4'd1; mod = 3'd1;
    exp = model(op, mod, tmask, rs1, rs2);
    run_req();
    checks++;
    if (s_timeout || s_data !== exp) begin errors++; $display("FAIL l2_mulh: got %h expected %h", s_data, exp); end
    cur_b = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_dot();
    test_mulh();
    test_absdiff();
    test_backpressure();
    test_reset_exec();
    test_lanes2();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
